ishift_arb: RTL and testbench
=============================

# ishift_arb

Two-port arbiter and sequencer for the coprocessor's iterative shifter. Accepts shift requests from two independent requesters, grants them round-robin, latches operands, drives the shifter's go/fmt/cnt/a inputs and watches its busy flag. Returns the result on a shared bus with a per-port done pulse. Sits between the CPU coprocessor port (port 0) and a secondary master such as a DMA/formatting engine (port 1), on one side, and the `ishift` instance on the other.

## Interface
- WIDTH, 16: data width; must match the shifter; 2..63.
- clk  in  1  system clock, all state on rising edge.
- arstn  in  1  asynchronous active-low reset.
- rq0_req / rq1_req  in  1  request, held high until that port's done pulse.
- rq0_fmt / rq1_fmt  in  2  shift format: 00 logical right, x1 left, 10 arithmetic right.
- rq0_cnt / rq1_cnt  in  6  shift count.
- rq0_a / rq1_a  in  WIDTH  operand.
- rq0_done / rq1_done  out  1  one-cycle pulse: result valid on y this cycle.
- y  out  WIDTH  result register; holds last result until next done.
- arb_busy  out  1  high whenever state ≠ IDLE.
- sh_go  out  1  shifter trigger, one-cycle pulse.
- sh_fmt  out  2, sh_cnt  out  6, sh_a  out  WIDTH  latched operands to shifter.
- sh_busy  in  1  shifter busy flag.
- sh_y  in  WIDTH  shifter output.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req high, grant per round-robin, latch fmt/cnt/a of winner into sh_fmt/sh_cnt/sh_a, record granted port, go ISSUE. Otherwise stay.
- Round-robin: register `last` (port last served). Both requesting → grant port ≠ last. One requesting → grant it. `last` updates on DONE. Reset value last=1 so port 0 wins the first tie.
- Count clamp: latched sh_cnt = min(cnt, WIDTH). Result is identical for every format (left/logical → 0, arithmetic → all sign bits) and saves cycles.
- ISSUE: sh_go=1 for exactly this cycle; go WAIT.
- WAIT: stay while sh_busy=1; when sh_busy=0, capture sh_y into y and go DONE.
- DONE: assert done of the granted port (only that one), update last, go IDLE.
- Requests are sampled only in IDLE. A req still high in the IDLE after done is treated as a new request, so requesters must drop req the cycle after done.
- Operands are read only at grant; changes afterwards are ignored.
- sh_fmt/sh_cnt/sh_a hold their values after the operation (shifter reads them only on go).
- Reset (arstn low, any time including mid-operation): state=IDLE, sh_go=0, rq0_done=rq1_done=0, arb_busy=0, y=0, sh_fmt=0, sh_cnt=0, sh_a=0, last=1.
  - The shifter shares arstn, so no operation is left pending. An interrupted request is not completed and must be re-issued.

## Timing
- Cycle T0: req seen in IDLE (grant + latch). T1: ISSUE, sh_go=1. T2: first WAIT cycle, sh_busy already valid.
- Clamped count N>0: sh_busy high T2..T(N+1); WAIT sees 0 at T(N+2); done at T(N+3).
- N=0: done at T3.
- Request-to-done latency = N+3 cycles. Throughput: one op per N+4 cycles (IDLE slot between ops).
- y changes only on the edge entering DONE, so y equals the new result in the done cycle.
- Done pulses are never simultaneous, never longer than one cycle.
- sh_go is never asserted while sh_busy=1.

## Test plan
- Single port 0 op: WIDTH=16, fmt=01, cnt=4, a=0x0123 → rq0_done at T7, y=0x1230; rq1_done stays 0; sh_go high exactly one cycle.
- Arithmetic right with clamp: fmt=10, cnt=40, a=0x8001 → sh_cnt=16, y=0xFFFF, done at T19 (not T43).
- Zero count: port 1, fmt=00, cnt=0, a=0xBEEF → rq1_done at T3, y=0xBEEF.
- Simultaneous requests after reset: both req high, port 0 cnt=1 a=0x0002 fmt=00, port 1 cnt=2 a=0x0001 fmt=01.
  - Required: port 0 served first (y=0x0001), then port 1 (y=0x0004).
  - Repeat with both held → grants alternate 0,1,0,1.
- Reset mid-operation: assert arstn low during WAIT of a cnt=10 op → all outputs at reset values immediately. After release, no done pulse for the aborted op; a new request completes normally.
- Operand change after grant: alter rq0_a in T1..T3 → y reflects the value latched at T0.

Source files
------------

// File: rtl/ishift_arb.sv
// Round-robin two-port front end for the iterative shifter.
// Grants a requester, latches its operands, fires the shifter, and returns the result with a per-port done pulse.
`timescale 1ns/1ps
module ishift_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             rq0_req,
  input  logic [1:0]       rq0_fmt,
  input  logic [5:0]       rq0_cnt,
  input  logic [WIDTH-1:0] rq0_a,
  input  logic             rq1_req,
  input  logic [1:0]       rq1_fmt,
  input  logic [5:0]       rq1_cnt,
  input  logic [WIDTH-1:0] rq1_a,
  output logic             rq0_done,
  output logic             rq1_done,
  output logic [WIDTH-1:0] y,
  output logic             arb_busy,
  output logic             sh_go,
  output logic [1:0]       sh_fmt,
  output logic [5:0]       sh_cnt,
  output logic [WIDTH-1:0] sh_a,
  input  logic             sh_busy,
  input  logic [WIDTH-1:0] sh_y
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [5:0] CNT_MAX = 6'(WIDTH);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [1:0]       fmt_q, fmt_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic             sel;
  logic [5:0]       sel_cnt;

  // Both requesting: the port not served last wins; otherwise the lone requester.
  assign sel     = (rq0_req && rq1_req) ? ~last_q : rq1_req;
  assign sel_cnt = sel ? rq1_cnt : rq0_cnt;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      fmt_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      fmt_q   <= fmt_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    fmt_d    = fmt_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    y_d      = y_q;
    sh_go    = 1'b0;
    rq0_done = 1'b0;
    rq1_done = 1'b0;
    arb_busy = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (rq0_req || rq1_req) begin
          gnt_d   = sel;
          fmt_d   = sel ? rq1_fmt : rq0_fmt;
          a_d     = sel ? rq1_a : rq0_a;
          // Counts at or beyond WIDTH all give the same result, so cap the cycle cost.
          cnt_d   = (sel_cnt > CNT_MAX) ? CNT_MAX : sel_cnt;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sh_go   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (!sh_busy) begin
          y_d     = sh_y;
          state_d = DONE;
        end
      end
      DONE: begin
        rq0_done = ~gnt_q;
        rq1_done = gnt_q;
        last_d   = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign y      = y_q;
  assign sh_fmt = fmt_q;
  assign sh_cnt = cnt_q;
  assign sh_a   = a_q;

endmodule

// File: tb/tb_ishift_arb.sv
// Directed bench for ishift_arb with a behavioural iterative shifter attached to its shifter port.
`timescale 1ns/1ps
module tb_ishift_arb;

  logic        clk = 1'b0;
  logic        arstn;
  logic        rq0_req, rq1_req;
  logic [1:0]  rq0_fmt, rq1_fmt;
  logic [5:0]  rq0_cnt, rq1_cnt;
  logic [15:0] rq0_a, rq1_a;
  logic        rq0_done, rq1_done, arb_busy, sh_go, sh_busy;
  logic [15:0] y, sh_a, sh_y;
  logic [1:0]  sh_fmt;
  logic [5:0]  sh_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ishift_arb #(.WIDTH(16)) dut (
    .clk(clk), .arstn(arstn),
    .rq0_req(rq0_req), .rq0_fmt(rq0_fmt), .rq0_cnt(rq0_cnt), .rq0_a(rq0_a),
    .rq1_req(rq1_req), .rq1_fmt(rq1_fmt), .rq1_cnt(rq1_cnt), .rq1_a(rq1_a),
    .rq0_done(rq0_done), .rq1_done(rq1_done), .y(y), .arb_busy(arb_busy),
    .sh_go(sh_go), .sh_fmt(sh_fmt), .sh_cnt(sh_cnt), .sh_a(sh_a),
    .sh_busy(sh_busy), .sh_y(sh_y)
  );

  // Shifter model: result available the cycle after go, busy for sh_cnt cycles.
  logic [5:0] bcnt;
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bcnt <= '0;
      sh_y <= '0;
    end else if (sh_go) begin
      bcnt <= sh_cnt;
      if (sh_fmt[0])           sh_y <= sh_a << sh_cnt;
      else if (sh_fmt == 2'b10) sh_y <= $signed(sh_a) >>> sh_cnt;
      else                     sh_y <= sh_a >> sh_cnt;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 6'd1;
    end
  end
  assign sh_busy = (bcnt != 0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int p, input logic [1:0] f, input logic [5:0] c,
                        input logic [15:0] a, input logic [15:0] ey, input int elat,
                        input logic [5:0] ecnt, input bit perturb, input string tag);
    int lat = -1;
    int gos = 0;
    int other = 0;
    int clash = 0;
    if (p == 0) begin rq0_fmt = f; rq0_cnt = c; rq0_a = a; rq0_req = 1'b1; end
    else        begin rq1_fmt = f; rq1_cnt = c; rq1_a = a; rq1_req = 1'b1; end
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (perturb && i <= 3) begin
        if (p == 0) rq0_a = ~a; else rq1_a = ~a;
      end
      if (sh_go) gos++;
      if (sh_go && sh_busy) clash++;
      if ((p == 0) ? rq1_done : rq0_done) other++;
      if ((p == 0) ? rq0_done : rq1_done) begin
        lat = i;
        break;
      end
    end
    rq0_req = 1'b0;
    rq1_req = 1'b0;
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_go_pulses"}, gos, 1);
    chk({tag, "_go_while_busy"}, clash, 0);
    chk({tag, "_other_done"}, other, 0);
    chk({tag, "_sh_cnt"}, sh_cnt, ecnt);
    @(negedge clk);
    chk({tag, "_idle_after"}, arb_busy, 1'b0);
    chk({tag, "_y_hold"}, y, ey);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_go"}, sh_go, 1'b0);
    chk({tag, "_done0"}, rq0_done, 1'b0);
    chk({tag, "_done1"}, rq1_done, 1'b0);
    chk({tag, "_busy"}, arb_busy, 1'b0);
    chk({tag, "_y"}, y, 16'h0000);
    chk({tag, "_fmt"}, sh_fmt, 2'b00);
    chk({tag, "_cnt"}, sh_cnt, 6'd0);
    chk({tag, "_a"}, sh_a, 16'h0000);
  endtask

  initial begin
    logic [15:0] exp_y [4];
    int found;
    int stray;
    arstn = 1'b0;
    rq0_req = 1'b0; rq0_fmt = '0; rq0_cnt = '0; rq0_a = '0;
    rq1_req = 1'b0; rq1_fmt = '0; rq1_cnt = '0; rq1_a = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    arstn = 1'b1;
    @(negedge clk);

    // Tie after reset: port 0 first, then alternation while both stay high.
    exp_y[0] = 16'h0001; exp_y[1] = 16'h0004; exp_y[2] = 16'h0001; exp_y[3] = 16'h0004;
    rq0_fmt = 2'b00; rq0_cnt = 6'd1; rq0_a = 16'h0002;
    rq1_fmt = 2'b01; rq1_cnt = 6'd2; rq1_a = 16'h0001;
    rq0_req = 1'b1; rq1_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      found = -1;
      for (int i = 1; i <= 50; i++) begin
        @(negedge clk);
        if (rq0_done || rq1_done) begin
          found = i;
          break;
        end
      end
      if (n == 0) chk("tie_first_latency", found, 4);
      else        chk("tie_found", (found > 0), 1'b1);
      chk("tie_not_both", (rq0_done && rq1_done), 1'b0);
      chk("tie_port", rq1_done, 1'((n % 2) == 1));
      chk("tie_y", y, exp_y[n]);
    end
    rq0_req = 1'b0; rq1_req = 1'b0;
    repeat (2) @(negedge clk);

    run_op(0, 2'b01, 6'd4,  16'h0123, 16'h1230, 7,  6'd4,  1'b0, "single0");
    run_op(0, 2'b10, 6'd40, 16'h8001, 16'hFFFF, 19, 6'd16, 1'b0, "clamp_ar");
    run_op(1, 2'b00, 6'd63, 16'h8001, 16'h0000, 19, 6'd16, 1'b0, "clamp_lr");
    run_op(1, 2'b00, 6'd0,  16'hBEEF, 16'hBEEF, 3,  6'd0,  1'b0, "zero1");
    run_op(0, 2'b00, 6'd4,  16'hF000, 16'h0F00, 7,  6'd4,  1'b1, "late_op");
    run_op(1, 2'b11, 6'd16, 16'h0001, 16'h0000, 19, 6'd16, 1'b0, "left_w");

    // Abort mid-WAIT, then confirm the aborted op never completes.
    rq0_fmt = 2'b01; rq0_cnt = 6'd10; rq0_a = 16'h1234; rq0_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_busy", arb_busy, 1'b1);
    chk("mid_sh_busy", sh_busy, 1'b1);
    arstn = 1'b0;
    rq0_req = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rq0_done || rq1_done || arb_busy) stray++;
    end
    chk("no_stray_done", stray, 0);
    run_op(0, 2'b00, 6'd8, 16'hABCD, 16'h00AB, 11, 6'd8, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
